neighbor_expander: RTL and testbench
====================================

NEIGHBOR_EXPANDER -- requirements
Module: neighbor_expander

Interface
REQ-001 SHALL have parameter GRID_DIM, default 256, grid side length; coordinates range 0..GRID_DIM-1.
REQ-002 SHALL have parameter COORD_W, default 8, coordinate width; GRID_DIM <= 2**COORD_W.
REQ-003 SHALL have parameter COST_W, default 16, width of g/h/f costs.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cur_valid / cur_ready  input / output  1 / 1  handshake for the node popped from the priority queue.
REQ-007 cur_i, cur_j  input  COORD_W  popped node coordinates.
REQ-008 cur_g  input  COST_W  popped node path cost.
REQ-009 goal_i, goal_j  input  COORD_W  goal coordinates, sampled with the popped node.
REQ-010 occ_req  output  1  one-cycle occupancy lookup strobe.
REQ-011 occ_addr  output  2*COORD_W  lookup address, row-major: i*GRID_DIM+j.
REQ-012 occ_blocked  input  1  obstacle flag, valid exactly one cycle after occ_req.
REQ-013 nb_valid / nb_ready  output / input  1 / 1  successor handshake toward the priority-queue insert port.
REQ-014 nb_i, nb_j, nb_parent_i, nb_parent_j  output  COORD_W  successor and parent coordinates.
REQ-015 nb_g, nb_h, nb_f  output  COST_W  successor costs.
REQ-016 nb_count  output  4  successors emitted for the current node.
REQ-017 done  output  1  one-cycle pulse when expansion of a node completes.

Function
REQ-018 FSM states IDLE, PROBE, WAIT_OCC, EMIT, FINISH; cur_ready=1 only in IDLE.
REQ-019 IDLE: on cur_valid&cur_ready, register cur_*, goal_*, clear candidate index and nb_count, go to PROBE.
REQ-020 Candidate order N(i-1,j), E(i,j+1), S(i+1,j), W(i,j-1); with the diagonal feature, also NE, SE, SW, NW.
REQ-021 PROBE: out-of-bounds candidate (underflow below 0 or >= GRID_DIM) is skipped in one cycle with no occ_req; in-bounds candidate asserts occ_req and occ_addr, then goes to WAIT_OCC.
REQ-022 WAIT_OCC: sample occ_blocked; blocked -> next candidate via PROBE; free -> register nb_* outputs, go to EMIT.
REQ-023 EMIT: hold nb_valid=1 with all nb_* stable until nb_ready; on nb_valid&nb_ready increment nb_count, advance candidate.
REQ-024 After the last candidate, enter FINISH: assert done for exactly one cycle, then return to IDLE.
REQ-025 Orthogonal step cost is 10; nb_g = cur_g + step, saturating at 2**COST_W-1.
REQ-026 nb_h = 10*(|di|+|dj|) to goal; nb_f = nb_g + nb_h, saturating at 2**COST_W-1.
REQ-027 nb_parent_i/j equal the registered cur_i/cur_j.
REQ-028 Latency: node accepted at cycle T, first in-bounds free successor has nb_valid=1 at T+3 when N is in-bounds.
REQ-029 A new node is never accepted until done has pulsed; cur_valid outside IDLE is ignored.

Reset
REQ-030 On rst: state=IDLE; nb_valid, occ_req, done, nb_count, and all nb_*/occ_addr data = 0; cur_ready=1 from the first cycle after rst deasserts.
REQ-031 rst mid-expansion aborts immediately; the partial node is discarded and done is not pulsed.

Configuration
REQ-032 Macro NEIGHBOR_EXPANDER_DIAGONAL_EN: defined -> 8 candidates, diagonal step cost 14, nb_h octile = 14*min(|di|,|dj|)+10*(max-min); undefined -> 4 candidates, Manhattan per REQ-026.

Verification
REQ-033 GRID_DIM=16, cur=(5,5) g=20, goal=(9,5), no obstacles, macro off -> N(4,5) g30 h50 f80; E(5,6) g30 h50 f80; S(6,5) g30 h30 f60; W(5,4) g30 h50 f80; nb_count=4; done pulse.
REQ-034 cur=(0,0) -> only E(0,1), S(1,0) emitted; exactly 2 occ_req pulses; nb_count=2.
REQ-035 cur=(5,5), occ_blocked=1 for addr 86 (5,6) -> 3 successors, E absent, nb_count=3.
REQ-036 nb_ready low 5 cycles during EMIT -> nb_* unchanged, no successor lost or duplicated; cur_g=0xFFF5 -> nb_g=0xFFFF and nb_f=0xFFFF.
REQ-037 rst pulsed in EMIT -> nb_valid=0, no done, cur_ready=1 next cycle; a new node then expands normally.
REQ-038 Macro on, cur=(5,5) g=20, goal=(9,5) -> 8 successors; NE(4,6) g34 h54 f88; nb_count=8.

Source files
------------

// File: rtl/neighbor_expander_if.sv
// Handshake/bus bundle for neighbor_expander.
//   cur_*   : popped node from the priority queue (valid/ready)
//   goal_*  : goal coordinates, sampled together with the popped node
//   occ_*   : occupancy lookup (strobe + address out, blocked flag one cycle later)
//   nb_*    : successor stream toward the priority-queue insert port (valid/ready)
//   done    : one-cycle pulse when a node's expansion completes
// master = expander side, slave = environment side.
interface neighbor_expander_if #(
  parameter int COORD_W = 8,
  parameter int COST_W  = 16
);
  logic                   cur_valid, cur_ready;
  logic [COORD_W-1:0]     cur_i, cur_j, goal_i, goal_j;
  logic [COST_W-1:0]      cur_g;
  logic                   occ_req;
  logic [2*COORD_W-1:0]   occ_addr;
  logic                   occ_blocked;
  logic                   nb_valid, nb_ready;
  logic [COORD_W-1:0]     nb_i, nb_j, nb_parent_i, nb_parent_j;
  logic [COST_W-1:0]      nb_g, nb_h, nb_f;
  logic [3:0]             nb_count;
  logic                   done;

  modport master (
    input  cur_valid, cur_i, cur_j, cur_g, goal_i, goal_j, occ_blocked, nb_ready,
    output cur_ready, occ_req, occ_addr, nb_valid, nb_i, nb_j, nb_parent_i,
           nb_parent_j, nb_g, nb_h, nb_f, nb_count, done
  );
  modport slave (
    output cur_valid, cur_i, cur_j, cur_g, goal_i, goal_j, occ_blocked, nb_ready,
    input  cur_ready, occ_req, occ_addr, nb_valid, nb_i, nb_j, nb_parent_i,
           nb_parent_j, nb_g, nb_h, nb_f, nb_count, done
  );
endinterface

// File: rtl/neighbor_expander.sv
// neighbor_expander: A* node expansion. Accepts one popped node, walks its
// candidate neighbours (N,E,S,W; plus NE,SE,SW,NW when
// NEIGHBOR_EXPANDER_DIAGONAL_EN is defined), skips out-of-grid candidates,
// probes occupancy for the rest and emits free successors with g/h/f costs
// (saturating). Pulses done once all candidates are handled.
// Ports: clk, rst (async, active-high), bus (neighbor_expander_if.master).
module neighbor_expander #(
  parameter int GRID_DIM = 256,
  parameter int COORD_W  = 8,
  parameter int COST_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  neighbor_expander_if.master  bus
);

`ifdef NEIGHBOR_EXPANDER_DIAGONAL_EN
  localparam int NUM_CAND = 8;
`else
  localparam int NUM_CAND = 4;
`endif
  localparam logic [2:0]           LAST = 3'(NUM_CAND - 1);
  localparam int                   HW   = COST_W + COORD_W + 6;
  localparam logic [COORD_W:0]     GD   = (COORD_W+1)'(GRID_DIM);
  localparam logic [2*COORD_W-1:0] GD2  = (2*COORD_W)'(GRID_DIM);
  localparam logic [COST_W-1:0]    MAXC = '1;
  localparam logic [HW-1:0]        K10  = HW'(10);
  localparam logic [HW-1:0]        K14  = HW'(14);

  typedef enum logic [2:0] {IDLE, PROBE, WAIT_OCC, EMIT, FINISH} state_t;
  state_t state, state_nxt;

  logic [COORD_W-1:0] r_i, r_j, r_gi, r_gj;
  logic [COST_W-1:0]  r_g;
  logic [2:0]         idx;
  logic               adv, load;

  // Candidate offsets; -1 is all-ones in COORD_W+1 bits, so i=0 wraps far
  // above GRID_DIM and falls out through the single bounds compare.
  logic [COORD_W:0] off_i, off_j, cand_i, cand_j;
  always_comb begin
    off_i = '0;
    off_j = '0;
    case (idx)
      3'd0: off_i = '1;                    // N
      3'd1: off_j = (COORD_W+1)'(1);       // E
      3'd2: off_i = (COORD_W+1)'(1);       // S
      3'd3: off_j = '1;                    // W
      3'd4: begin off_i = '1;               off_j = (COORD_W+1)'(1); end // NE
      3'd5: begin off_i = (COORD_W+1)'(1);  off_j = (COORD_W+1)'(1); end // SE
      3'd6: begin off_i = (COORD_W+1)'(1);  off_j = '1;              end // SW
      default: begin off_i = '1;            off_j = '1;              end // NW
    endcase
  end

  assign cand_i = {1'b0, r_i} + off_i;
  assign cand_j = {1'b0, r_j} + off_j;

  logic               in_bounds, is_diag;
  logic [COORD_W-1:0] ci, cj, adi, adj, mn, mx;
  assign in_bounds = (cand_i < GD) && (cand_j < GD);
  assign is_diag   = idx[2];
  assign ci        = cand_i[COORD_W-1:0];
  assign cj        = cand_j[COORD_W-1:0];
  assign adi       = (ci >= r_gi) ? ci - r_gi : r_gi - ci;
  assign adj       = (cj >= r_gj) ? cj - r_gj : r_gj - cj;
  assign mn        = (adi < adj) ? adi : adj;
  assign mx        = (adi < adj) ? adj : adi;

  // Costs: heuristic computed wide, then all three saturate at COST_W.
  logic [HW-1:0]     h_full;
  logic [COST_W:0]   step, g_full, f_full;
  logic [COST_W-1:0] g_sat, h_sat, f_sat;
`ifdef NEIGHBOR_EXPANDER_DIAGONAL_EN
  assign h_full = K14 * HW'(mn) + K10 * HW'(mx - mn);
`else
  assign h_full = K10 * (HW'(adi) + HW'(adj));
`endif
  assign step   = is_diag ? (COST_W+1)'(14) : (COST_W+1)'(10);
  assign g_full = {1'b0, r_g} + step;
  assign g_sat  = g_full[COST_W] ? MAXC : g_full[COST_W-1:0];
  assign h_sat  = (h_full > HW'(MAXC)) ? MAXC : h_full[COST_W-1:0];
  assign f_full = {1'b0, g_sat} + {1'b0, h_sat};
  assign f_sat  = f_full[COST_W] ? MAXC : f_full[COST_W-1:0];

  assign bus.occ_addr = (state == PROBE && in_bounds)
                      ? (2*COORD_W)'(ci) * GD2 + (2*COORD_W)'(cj) : '0;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt     = state;
    bus.cur_ready = 1'b0;
    bus.occ_req   = 1'b0;
    bus.nb_valid  = 1'b0;
    bus.done      = 1'b0;
    adv           = 1'b0;
    load          = 1'b0;
    case (state)
      IDLE: begin
        bus.cur_ready = 1'b1;
        if (bus.cur_valid) state_nxt = PROBE;
      end
      PROBE: begin
        if (in_bounds) begin
          bus.occ_req = 1'b1;
          state_nxt   = WAIT_OCC;
        end else adv = 1'b1;
      end
      WAIT_OCC: begin
        if (bus.occ_blocked) adv = 1'b1;
        else begin
          load      = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        bus.nb_valid = 1'b1;
        if (bus.nb_ready) adv = 1'b1;
      end
      FINISH: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (adv) state_nxt = (idx == LAST) ? FINISH : PROBE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i <= '0; r_j <= '0; r_gi <= '0; r_gj <= '0; r_g <= '0; idx <= '0;
      bus.nb_count    <= '0;
      bus.nb_i        <= '0;
      bus.nb_j        <= '0;
      bus.nb_parent_i <= '0;
      bus.nb_parent_j <= '0;
      bus.nb_g        <= '0;
      bus.nb_h        <= '0;
      bus.nb_f        <= '0;
    end else begin
      if (state == IDLE && bus.cur_valid) begin
        r_i  <= bus.cur_i;
        r_j  <= bus.cur_j;
        r_g  <= bus.cur_g;
        r_gi <= bus.goal_i;
        r_gj <= bus.goal_j;
        idx  <= '0;
        bus.nb_count <= '0;
      end
      if (adv) idx <= idx + 3'd1;
      if (state == EMIT && bus.nb_ready) bus.nb_count <= bus.nb_count + 4'd1;
      if (load) begin
        bus.nb_i        <= ci;
        bus.nb_j        <= cj;
        bus.nb_parent_i <= r_i;
        bus.nb_parent_j <= r_j;
        bus.nb_g        <= g_sat;
        bus.nb_h        <= h_sat;
        bus.nb_f        <= f_sat;
      end
    end
  end

endmodule

// File: tb/tb_neighbor_expander.sv
// Directed self-checking bench for neighbor_expander on a 16x16 grid.
// Successors are packed as {i,j,g,h,f} and compared against hand-computed tables.
module tb_neighbor_expander;
  localparam int GD = 16, CW = 8, KW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neighbor_expander_if #(.COORD_W(CW), .COST_W(KW)) bus ();
  neighbor_expander #(.GRID_DIM(GD), .COORD_W(CW), .COST_W(KW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [7:0] i, input logic [7:0] j,
                                     input logic [15:0] g, input logic [15:0] h,
                                     input logic [15:0] f);
    return {i, j, g, h, f};
  endfunction

  // Environment: occupancy memory with one blockable address, plus monitors.
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [15:0] blk_addr = '0;
  logic        blk_en = 1'b0;
  logic [7:0]  exp_pi = '0, exp_pj = '0;
  int occ_cnt = 0, done_cnt = 0, parent_err = 0;
  int occ_base, done_base;

  always @(posedge clk) begin
    bus.occ_blocked <= bus.occ_req && blk_en && (bus.occ_addr == blk_addr);
    if (bus.occ_req) occ_cnt++;
    if (bus.done) done_cnt++;
    if (bus.nb_valid && bus.nb_ready) begin
      got_q.push_back({bus.nb_i, bus.nb_j, bus.nb_g, bus.nb_h, bus.nb_f});
      if ({bus.nb_parent_i, bus.nb_parent_j} !== {exp_pi, exp_pj}) parent_err++;
    end
  end

  task automatic start_node(input logic [7:0] ci, input logic [7:0] cj, input logic [15:0] g);
    @(negedge clk);
    chk("cur_ready_idle", 64'(bus.cur_ready), 64'd1);
    occ_base = occ_cnt;
    done_base = done_cnt;
    bus.cur_valid = 1'b1;
    bus.cur_i = ci; bus.cur_j = cj; bus.cur_g = g;
    bus.goal_i = 8'd9; bus.goal_j = 8'd5;
    exp_pi = ci; exp_pj = cj;
    @(negedge clk);
    bus.cur_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 300 && done_cnt == done_base; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, 64'(done_cnt - done_base), 64'd1);
    chk({tag, "_ready"}, 64'(bus.cur_ready), 64'd1);
  endtask

  task automatic check_list(input string tag, input int base);
    chk({tag, "_n"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    chk({tag, "_count"}, 64'(bus.nb_count), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      chk($sformatf("%s_%0d", tag, k), (base + k < got_q.size()) ? got_q[base + k] : 64'd0, exp_q[k]);
  endtask

  // cur=(5,5) g=20 goal=(9,5)
  task automatic make_center();
    exp_q = {};
    exp_q.push_back(pk(8'd4, 8'd5, 16'd30, 16'd50, 16'd80));
`ifdef NEIGHBOR_EXPANDER_DIAGONAL_EN
    exp_q.push_back(pk(8'd5, 8'd6, 16'd30, 16'd44, 16'd74));
    exp_q.push_back(pk(8'd6, 8'd5, 16'd30, 16'd30, 16'd60));
    exp_q.push_back(pk(8'd5, 8'd4, 16'd30, 16'd44, 16'd74));
    exp_q.push_back(pk(8'd4, 8'd6, 16'd34, 16'd54, 16'd88));
    exp_q.push_back(pk(8'd6, 8'd6, 16'd34, 16'd34, 16'd68));
    exp_q.push_back(pk(8'd6, 8'd4, 16'd34, 16'd34, 16'd68));
    exp_q.push_back(pk(8'd4, 8'd4, 16'd34, 16'd54, 16'd88));
`else
    exp_q.push_back(pk(8'd5, 8'd6, 16'd30, 16'd50, 16'd80));
    exp_q.push_back(pk(8'd6, 8'd5, 16'd30, 16'd30, 16'd60));
    exp_q.push_back(pk(8'd5, 8'd4, 16'd30, 16'd50, 16'd80));
`endif
  endtask

  int base, d0;
  logic [63:0] snap;

  initial begin
    rst = 1'b1;
    bus.cur_valid = 1'b0; bus.nb_ready = 1'b1;
    bus.cur_i = '0; bus.cur_j = '0; bus.cur_g = '0; bus.goal_i = '0; bus.goal_j = '0;
    repeat (3) @(negedge clk);
    chk("rst_nb_valid", 64'(bus.nb_valid), 64'd0);
    chk("rst_occ_req", 64'(bus.occ_req), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_data", {bus.nb_i, bus.nb_j, bus.nb_g, bus.nb_h, bus.nb_f}, 64'd0);
    chk("rst_addr_cnt", {44'd0, bus.occ_addr, bus.nb_count}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_cur_ready", 64'(bus.cur_ready), 64'd1);

    // Centre node, no obstacles, with first-successor latency.
    base = got_q.size();
    start_node(8'd5, 8'd5, 16'd20);
    chk("lat_probe", 64'(bus.nb_valid), 64'd0);
    @(negedge clk); chk("lat_wait", 64'(bus.nb_valid), 64'd0);
    @(negedge clk); chk("lat_emit", 64'(bus.nb_valid), 64'd1);
    wait_done("center");
    make_center();
    check_list("center", base);

    // Corner (0,0): only in-bounds candidates probed.
    base = got_q.size();
    start_node(8'd0, 8'd0, 16'd20);
    wait_done("corner");
    exp_q = {};
`ifdef NEIGHBOR_EXPANDER_DIAGONAL_EN
    exp_q.push_back(pk(8'd0, 8'd1, 16'd30, 16'd106, 16'd136));
    exp_q.push_back(pk(8'd1, 8'd0, 16'd30, 16'd100, 16'd130));
    exp_q.push_back(pk(8'd1, 8'd1, 16'd34, 16'd96, 16'd130));
`else
    exp_q.push_back(pk(8'd0, 8'd1, 16'd30, 16'd130, 16'd160));
    exp_q.push_back(pk(8'd1, 8'd0, 16'd30, 16'd130, 16'd160));
`endif
    chk("corner_occ", 64'(occ_cnt - occ_base), 64'(exp_q.size()));
    check_list("corner", base);

    // E neighbour (5,6) -> addr 86 blocked.
    blk_addr = 16'd86; blk_en = 1'b1;
    base = got_q.size();
    start_node(8'd5, 8'd5, 16'd20);
    wait_done("blocked");
    blk_en = 1'b0;
    make_center();
    exp_q.delete(1);
    check_list("blocked", base);

    // Back-pressure during EMIT plus cost saturation.
    bus.nb_ready = 1'b0;
    base = got_q.size();
    start_node(8'd5, 8'd5, 16'hFFF5);
    for (int k = 0; k < 20 && !bus.nb_valid; k++) @(negedge clk);
    chk("stall_valid", 64'(bus.nb_valid), 64'd1);
    snap = {bus.nb_i, bus.nb_j, bus.nb_g, bus.nb_h, bus.nb_f};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_hold_%0d", k),
          {bus.nb_valid, bus.nb_i, bus.nb_j, bus.nb_g, bus.nb_h, bus.nb_f[14:0]},
          {1'b1, snap[63:16], snap[14:0]});
    end
    bus.nb_ready = 1'b1;
    wait_done("stall");
    make_center();
    for (int k = 0; k < exp_q.size(); k++) exp_q[k] = exp_q[k] | 64'h0000_FFFF_0000_FFFF;
    check_list("stall", base);

    // Reset in EMIT aborts without done; next node expands normally.
    bus.nb_ready = 1'b0;
    start_node(8'd5, 8'd5, 16'd20);
    for (int k = 0; k < 20 && !bus.nb_valid; k++) @(negedge clk);
    chk("abort_in_emit", 64'(bus.nb_valid), 64'd1);
    d0 = done_cnt;
    rst = 1'b1; #1;
    chk("abort_nb_valid", 64'(bus.nb_valid), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_cur_ready", 64'(bus.cur_ready), 64'd1);
    chk("abort_count", 64'(bus.nb_count), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    bus.nb_ready = 1'b1;
    base = got_q.size();
    start_node(8'd5, 8'd5, 16'd20);
    wait_done("after_abort");
    make_center();
    check_list("after_abort", base);

    chk("parent", 64'(parent_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
